// File: rtl/mnacidpro_ctrl_seq.sv
// Run sequencer for the mnacidpro nucleic-acid prep cartridge: steps through
// load/lyse/bind/wash/elute/collect and drives the valve and peristaltic pump pads.
module mnacidpro_ctrl_seq #(
  parameter int DUR_W    = 16,
  parameter int PUMP_DIV = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [DUR_W-1:0] dur_load,
  input  logic [DUR_W-1:0] dur_lyse,
  input  logic [DUR_W-1:0] dur_bind,
  input  logic [DUR_W-1:0] dur_wash,
  input  logic [DUR_W-1:0] dur_elute,
  input  logic [DUR_W-1:0] dur_collect,
  input  logic [2:0]       wash_reps,
  output logic [10:0]      valve,
  output logic [2:0]       pump,
  output logic             busy,
  output logic             done,
  output logic             aborted,
  output logic [2:0]       step
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD    = 3'd1,
    LYSE    = 3'd2,
    BIND    = 3'd3,
    WASH    = 3'd4,
    ELUTE   = 3'd5,
    COLLECT = 3'd6,
    DONE    = 3'd7
  } state_t;

  localparam int V_LYSIS     = 0;
  localparam int V_WASH      = 1;
  localparam int V_ELUTE     = 2;
  localparam int V_DEAD_END  = 3;
  localparam int V_VERTICAL  = 4;
  localparam int V_HORIZ     = 5;
  localparam int V_WASTE     = 6;
  localparam int V_BEAD      = 7;
  localparam int V_LOOP_EXIT = 8;
  localparam int V_BEAD_TRAP = 9;
  localparam int V_COLLECT   = 10;

  function automatic logic [10:0] valve_of(input state_t s);
    logic [10:0] v;
    v = '0;
    case (s)
      LOAD:    begin v[V_BEAD] = 1'b1;      v[V_VERTICAL] = 1'b1;  v[V_WASTE] = 1'b1;    end
      LYSE:    begin v[V_LYSIS] = 1'b1;     v[V_HORIZ] = 1'b1;     v[V_DEAD_END] = 1'b1; end
      BIND:    begin v[V_LOOP_EXIT] = 1'b1; v[V_BEAD_TRAP] = 1'b1; v[V_WASTE] = 1'b1;    end
      WASH:    begin v[V_WASH] = 1'b1;      v[V_BEAD_TRAP] = 1'b1; v[V_WASTE] = 1'b1;    end
      ELUTE:   begin v[V_ELUTE] = 1'b1;     v[V_BEAD_TRAP] = 1'b1; v[V_HORIZ] = 1'b1;    end
      COLLECT: begin v[V_ELUTE] = 1'b1;     v[V_BEAD_TRAP] = 1'b1; v[V_COLLECT] = 1'b1;  end
      default: v = '0;
    endcase
    return v;
  endfunction

  function automatic logic pump_en(input state_t s);
    return (s == LOAD) || (s == LYSE) || (s == WASH) || (s == ELUTE);
  endfunction

  // Six-phase peristaltic drive pattern, phase 0 first.
  function automatic logic [2:0] pump_pat(input logic [2:0] p);
    case (p)
      3'd0:    return 3'b110;
      3'd1:    return 3'b100;
      3'd2:    return 3'b101;
      3'd3:    return 3'b001;
      3'd4:    return 3'b011;
      default: return 3'b010;
    endcase
  endfunction

  state_t           state_reg, state_next;
  logic [DUR_W-1:0] dur_in      [6];
  logic [DUR_W-1:0] dur_lat_reg [6];
  logic [DUR_W-1:0] dur_src     [6];
  logic [DUR_W-1:0] next_len;
  logic [2:0]       reps_lat_reg, reps_src, reps_eff;
  logic [DUR_W-1:0] cnt_reg;
  logic [2:0]       rep_reg;
  logic [2:0]       phase_reg, phase_adv;
  logic [7:0]       div_reg;
  logic             step_last, advance;

  assign dur_in[0] = dur_load;
  assign dur_in[1] = dur_lyse;
  assign dur_in[2] = dur_bind;
  assign dur_in[3] = dur_wash;
  assign dur_in[4] = dur_elute;
  assign dur_in[5] = dur_collect;

  // In IDLE the live inputs are used so the start edge can already pick the first step.
  generate
    for (genvar gi = 0; gi < 6; gi++) begin : g_src
      assign dur_src[gi] = (state_reg == IDLE) ? dur_in[gi] : dur_lat_reg[gi];
    end
  endgenerate

  assign reps_src  = (state_reg == IDLE) ? wash_reps : reps_lat_reg;
  assign reps_eff  = (reps_src == 3'd0) ? 3'd1 : reps_src;
  assign step_last = (cnt_reg == '0) && ((state_reg != WASH) || (rep_reg == 3'd0));
  assign phase_adv = (phase_reg == 3'd5) ? 3'd0 : phase_reg + 3'd1;
  assign step      = state_reg;

  always_comb begin
    advance    = 1'b0;
    state_next = state_reg;
    case (state_reg)
      IDLE:    advance = start && !abort;
      DONE:    state_next = IDLE;
      default: begin
        if (abort) state_next = IDLE;
        else       advance = step_last;
      end
    endcase
    // Lowest-numbered later step with a nonzero length wins; none left means DONE.
    if (advance) begin
      state_next = DONE;
      for (int k = 6; k >= 1; k--) begin
        if ((k > int'(state_reg)) && (dur_src[k-1] != '0)) state_next = state_t'(3'(k));
      end
    end
    next_len = '0;
    for (int k = 1; k <= 6; k++) begin
      if (state_next == state_t'(3'(k))) next_len = dur_src[k-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      valve        <= '0;
      pump         <= 3'b000;
      busy         <= 1'b0;
      done         <= 1'b0;
      aborted      <= 1'b0;
      cnt_reg      <= '0;
      rep_reg      <= 3'd0;
      phase_reg    <= 3'd0;
      div_reg      <= 8'd0;
      reps_lat_reg <= 3'd0;
      for (int i = 0; i < 6; i++) dur_lat_reg[i] <= '0;
    end else begin
      state_reg <= state_next;
      valve     <= valve_of(state_next);
      busy      <= (state_next != IDLE);
      done      <= (state_next == DONE);
      aborted   <= abort && (state_reg != IDLE);

      if ((state_reg == IDLE) && advance) begin
        for (int i = 0; i < 6; i++) dur_lat_reg[i] <= dur_in[i];
        reps_lat_reg <= wash_reps;
      end

      // cnt_reg holds remaining cycles minus one; WASH reloads it once per pass.
      if (state_next != state_reg) begin
        cnt_reg <= (next_len == '0) ? '0 : next_len - 1'b1;
        rep_reg <= (state_next == WASH) ? reps_eff - 3'd1 : 3'd0;
      end else if (cnt_reg != '0) begin
        cnt_reg <= cnt_reg - 1'b1;
      end else if (rep_reg != 3'd0) begin
        cnt_reg <= dur_src[3] - 1'b1;
        rep_reg <= rep_reg - 3'd1;
      end

      if (!pump_en(state_next)) begin
        phase_reg <= 3'd0;
        div_reg   <= 8'd0;
        pump      <= 3'b000;
      end else if (!pump_en(state_reg)) begin
        phase_reg <= 3'd0;
        div_reg   <= 8'd0;
        pump      <= pump_pat(3'd0);
      end else if (div_reg == 8'(PUMP_DIV - 1)) begin
        phase_reg <= phase_adv;
        div_reg   <= 8'd0;
        pump      <= pump_pat(phase_adv);
      end else begin
        div_reg   <= div_reg + 8'd1;
        pump      <= pump_pat(phase_reg);
      end
    end
  end

endmodule

// File: tb/tb_mnacidpro_ctrl_seq.sv
// Bench for mnacidpro_ctrl_seq: two instances (pump divider 2 and 1) share stimulus and
// are compared every cycle against a per-cycle trace expanded from the run configuration.
module tb_mnacidpro_ctrl_seq;

  localparam int DW    = 16;
  localparam int DIV_A = 2;
  localparam int DIV_B = 1;

  localparam int B_LYSIS = 0, B_WASH = 1, B_ELUTE = 2, B_DEAD_END = 3, B_VERTICAL = 4;
  localparam int B_HORIZ = 5, B_WASTE = 6, B_BEAD = 7, B_LOOP_EXIT = 8, B_BEAD_TRAP = 9;
  localparam int B_COLLECT = 10;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [DW-1:0] dur_load = '0, dur_lyse = '0, dur_bind = '0;
  logic [DW-1:0] dur_wash = '0, dur_elute = '0, dur_collect = '0;
  logic [2:0]    wash_reps = '0;

  logic [10:0] valve_a, valve_b;
  logic [2:0]  pump_a, pump_b, step_a, step_b;
  logic        busy_a, busy_b, done_a, done_b, aborted_a, aborted_b;

  mnacidpro_ctrl_seq #(.DUR_W(DW), .PUMP_DIV(DIV_A)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .dur_load(dur_load), .dur_lyse(dur_lyse), .dur_bind(dur_bind),
    .dur_wash(dur_wash), .dur_elute(dur_elute), .dur_collect(dur_collect),
    .wash_reps(wash_reps), .valve(valve_a), .pump(pump_a), .busy(busy_a),
    .done(done_a), .aborted(aborted_a), .step(step_a)
  );

  mnacidpro_ctrl_seq #(.DUR_W(DW), .PUMP_DIV(DIV_B)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .dur_load(dur_load), .dur_lyse(dur_lyse), .dur_bind(dur_bind),
    .dur_wash(dur_wash), .dur_elute(dur_elute), .dur_collect(dur_collect),
    .wash_reps(wash_reps), .valve(valve_b), .pump(pump_b), .busy(busy_b),
    .done(done_b), .aborted(aborted_b), .step(step_b)
  );

  always #5 clk = ~clk;

  typedef struct {
    int step;
    int valve;
    int pa;
    int pb;
    int busy;
    int done;
    int ab;
  } exp_t;

  int   total = 0;
  int   bad   = 0;
  int   cfg [6];
  int   cfg_reps;
  exp_t q [$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, want);
    end
  endtask

  function automatic int valve_for(input int s);
    case (s)
      1: return (1 << B_BEAD) | (1 << B_VERTICAL) | (1 << B_WASTE);
      2: return (1 << B_LYSIS) | (1 << B_HORIZ) | (1 << B_DEAD_END);
      3: return (1 << B_LOOP_EXIT) | (1 << B_BEAD_TRAP) | (1 << B_WASTE);
      4: return (1 << B_WASH) | (1 << B_BEAD_TRAP) | (1 << B_WASTE);
      5: return (1 << B_ELUTE) | (1 << B_BEAD_TRAP) | (1 << B_HORIZ);
      6: return (1 << B_ELUTE) | (1 << B_BEAD_TRAP) | (1 << B_COLLECT);
      default: return 0;
    endcase
  endfunction

  function automatic int pump_for(input int p);
    case (p)
      0: return 'b110;
      1: return 'b100;
      2: return 'b101;
      3: return 'b001;
      4: return 'b011;
      default: return 'b010;
    endcase
  endfunction

  function automatic exp_t idle_exp(input int ab);
    exp_t e;
    e.step = 0; e.valve = 0; e.pa = 0; e.pb = 0; e.busy = 0; e.done = 0; e.ab = ab;
    return e;
  endfunction

  // Expected trace, one entry per cycle after the start edge, ending with the IDLE cycle.
  function automatic void build();
    int steps [$];
    int r;
    exp_t e;
    q.delete();
    for (int k = 0; k < 6; k++) begin
      int len;
      len = (k == 3) ? cfg[k] * ((cfg_reps == 0) ? 1 : cfg_reps) : cfg[k];
      for (int j = 0; j < len; j++) steps.push_back(k + 1);
    end
    steps.push_back(7);
    steps.push_back(0);
    r = 0;
    foreach (steps[i]) begin
      e = idle_exp(0);
      e.step  = steps[i];
      e.valve = valve_for(steps[i]);
      e.busy  = (steps[i] != 0);
      e.done  = (steps[i] == 7);
      if (steps[i] inside {1, 2, 4, 5}) begin
        e.pa = pump_for((r / DIV_A) % 6);
        e.pb = pump_for((r / DIV_B) % 6);
        r++;
      end else begin
        r = 0;
      end
      q.push_back(e);
    end
  endfunction

  task automatic check_cycle(input string tag, input exp_t e);
    check_eq({tag, ".step_a"},    32'(step_a),    32'(e.step));
    check_eq({tag, ".step_b"},    32'(step_b),    32'(e.step));
    check_eq({tag, ".valve_a"},   32'(valve_a),   32'(e.valve));
    check_eq({tag, ".valve_b"},   32'(valve_b),   32'(e.valve));
    check_eq({tag, ".pump_a"},    32'(pump_a),    32'(e.pa));
    check_eq({tag, ".pump_b"},    32'(pump_b),    32'(e.pb));
    check_eq({tag, ".busy_a"},    32'(busy_a),    32'(e.busy));
    check_eq({tag, ".busy_b"},    32'(busy_b),    32'(e.busy));
    check_eq({tag, ".done_a"},    32'(done_a),    32'(e.done));
    check_eq({tag, ".done_b"},    32'(done_b),    32'(e.done));
    check_eq({tag, ".aborted_a"}, 32'(aborted_a), 32'(e.ab));
    check_eq({tag, ".aborted_b"}, 32'(aborted_b), 32'(e.ab));
  endtask

  task automatic drive_cfg();
    dur_load    = DW'(cfg[0]);
    dur_lyse    = DW'(cfg[1]);
    dur_bind    = DW'(cfg[2]);
    dur_wash    = DW'(cfg[3]);
    dur_elute   = DW'(cfg[4]);
    dur_collect = DW'(cfg[5]);
    wash_reps   = 3'(cfg_reps);
  endtask

  task automatic set_cfg(input int l, input int ly, input int b, input int w,
                         input int el, input int c, input int reps);
    cfg[0] = l; cfg[1] = ly; cfg[2] = b; cfg[3] = w; cfg[4] = el; cfg[5] = c;
    cfg_reps = reps;
  endtask

  // abort_at / reset_at: trace index where the event is raised; -1 = none, -2 = maybe random abort.
  task automatic run(input string name, input int abort_at_in, input int reset_at);
    int abort_at;
    string tag;
    build();
    abort_at = abort_at_in;
    if (abort_at == -2) abort_at = ($urandom % 4 == 0) ? $urandom_range(0, q.size() - 2) : -1;
    @(negedge clk);
    drive_cfg();
    start = 1'b1;
    abort = 1'b0;
    @(negedge clk);
    start       = 1'b0;
    dur_load    = DW'($urandom);
    dur_lyse    = DW'($urandom);
    dur_bind    = DW'($urandom);
    dur_wash    = DW'($urandom);
    dur_elute   = DW'($urandom);
    dur_collect = DW'($urandom);
    wash_reps   = 3'($urandom);
    for (int i = 0; i < q.size(); i++) begin
      tag = $sformatf("%s[%0d]", name, i);
      check_cycle(tag, q[i]);
      if (i == abort_at) begin
        start = 1'b0;
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check_cycle({tag, ".abort"}, idle_exp(1));
        @(negedge clk);
        check_cycle({tag, ".after_abort"}, idle_exp(0));
        break;
      end
      if (i == reset_at) begin
        start = 1'b0;
        #2 rst_n = 1'b0;
        #1 check_cycle({tag, ".async_rst"}, idle_exp(0));
        @(negedge clk);
        check_cycle({tag, ".in_rst"}, idle_exp(0));
        rst_n = 1'b1;
        @(negedge clk);
        check_cycle({tag, ".after_rst"}, idle_exp(0));
        break;
      end
      if (i < q.size() - 1) begin
        start = 1'($urandom);
        @(negedge clk);
      end
    end
    start = 1'b0;
    $display("run %s: load=%0d lyse=%0d bind=%0d wash=%0d elute=%0d collect=%0d reps=%0d cycles=%0d abort_at=%0d reset_at=%0d",
             name, cfg[0], cfg[1], cfg[2], cfg[3], cfg[4], cfg[5], cfg_reps, q.size(), abort_at, reset_at);
  endtask

  task automatic idle_abort_test();
    @(negedge clk);
    start = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    check_cycle("idle_start_abort", idle_exp(0));
    start = 1'b0;
    @(negedge clk);
    check_cycle("idle_abort", idle_exp(0));
    abort = 1'b0;
    $display("run idle_abort: start+abort and abort alone in IDLE");
  endtask

  initial begin
    #12;
    check_cycle("reset", idle_exp(0));
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_cycle("post_reset", idle_exp(0));

    set_cfg(2, 2, 2, 2, 2, 2, 1);   run("all2", -1, -1);
    set_cfg(1, 1, 1, 3, 1, 1, 2);   run("wash3x2", -1, -1);
    set_cfg(1, 1, 1, 3, 1, 1, 0);   run("wash3x0", -1, -1);
    set_cfg(14, 1, 2, 1, 1, 1, 1);  run("load14", -1, -1);
    set_cfg(0, 0, 0, 0, 0, 0, 3);   run("all0", -1, -1);
    set_cfg(0, 3, 0, 2, 0, 0, 7);   run("sparse", -1, -1);
    set_cfg(2, 2, 2, 2, 2, 2, 1);   run("abort_lyse", 2, -1);
    idle_abort_test();
    set_cfg(3, 3, 3, 3, 3, 3, 1);   run("reset_wash", -1, 10);
    set_cfg(2, 2, 2, 2, 2, 2, 1);   run("after_reset", -1, -1);

    for (int n = 0; n < 30; n++) begin
      for (int k = 0; k < 6; k++) cfg[k] = ($urandom % 3 == 0) ? 0 : $urandom_range(1, 4);
      cfg_reps = $urandom % 8;
      run($sformatf("rand%0d", n), -2, -1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mnacidpro_ctrl_seq.md
MNACIDPRO_CTRL_SEQ -- requirements
Module: mnacidpro_ctrl_seq

Interface
REQ-001 SHALL have parameter DUR_W, default 16: width of every step-duration input and of the step counter.
REQ-002 SHALL have parameter PUMP_DIV, default 4: clocks per pump phase step, legal range 1..255.
REQ-003 SHALL have port clk, input, 1: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n, input, 1: reset, asynchronous and active-low.
REQ-005 SHALL have port start, input, 1: run request, sampled only in IDLE.
REQ-006 SHALL have port abort, input, 1: terminates any run.
REQ-007 SHALL have ports dur_load, dur_lyse, dur_bind, dur_wash, dur_elute, dur_collect, each input, DUR_W: step lengths in clocks.
REQ-008 SHALL have port wash_reps, input, 3: number of wash passes, with 0 treated as 1.
REQ-009 SHALL have port valve, output, 11: valve commands, 1 = open; bit order [10:0] = collect, bead_trap, loop_exit, bead, waste, horiz, vertical, dead_end, elute, wash, lysis; drives the lysis_ctrl..collect_ctrl pads of mnacidpro.
REQ-010 SHALL have port pump, output, 3: peristaltic pump chamber commands; drives the pump[2:0] pads.
REQ-011 SHALL have port busy, output, 1: high while a run is in progress.
REQ-012 SHALL have port done, output, 1: one-cycle pulse on normal completion.
REQ-013 SHALL have port aborted, output, 1: one-cycle pulse on abort.
REQ-014 SHALL have port step, output, 3: current state code.

Function
REQ-015 SHALL implement states with codes IDLE=0, LOAD=1, LYSE=2, BIND=3, WASH=4, ELUTE=5, COLLECT=6, DONE=7; step SHALL equal the current state code.
REQ-016 SHALL latch all dur_* inputs and wash_reps on the clock edge that accepts start; input changes during a run SHALL have no effect on that run.
REQ-017 SHALL accept start in IDLE at edge T and enter the first step whose duration is nonzero at T+1; busy SHALL be high from T+1 through the DONE cycle inclusive.
REQ-018 SHALL keep each step with duration D>0 active for exactly D cycles; a step with D=0 SHALL be skipped in zero cycles.
REQ-019 SHALL sequence the steps LOAD, LYSE, BIND, WASH×reps, ELUTE, COLLECT, DONE, IDLE; DONE SHALL last 1 cycle with done=1.
REQ-020 SHALL run WASH for reps×dur_wash contiguous cycles and SHALL skip WASH entirely when dur_wash=0.
REQ-021 SHALL go from IDLE through DONE at T+1 to IDLE at T+2 when all durations are 0.
REQ-022 SHALL drive the valves open per state (all other bits 0): IDLE/DONE: none; LOAD: bead, vertical, waste; LYSE: lysis, horiz, dead_end; BIND: loop_exit, bead_trap, waste; WASH: wash, bead_trap, waste; ELUTE: elute, bead_trap, horiz; COLLECT: elute, bead_trap, collect.
REQ-023 SHALL enable the pump in LOAD, LYSE, WASH and ELUTE only.
REQ-024 SHALL, while the pump is enabled, cycle pump through 110, 100, 101, 001, 011, 010 and wrap to 110, advancing one phase every PUMP_DIV clocks.
REQ-025 SHALL output pump 110 on the first cycle the pump is enabled.
REQ-026 SHALL force pump to 000 and reset the phase index and divider while the pump is disabled.
REQ-027 SHALL keep the pump phase continuous across adjacent pump-enabled steps, e.g. from LOAD to LYSE.
REQ-028 SHALL, on abort=1 in any non-IDLE state, return to IDLE on the next edge with valve=0, pump=000, busy=0 and aborted=1 for 1 cycle; done SHALL NOT pulse.
REQ-029 SHALL ignore abort in IDLE; start together with abort in IDLE SHALL be ignored.
REQ-030 SHALL ignore start while busy.

Reset
REQ-031 SHALL on rst_n=0, immediately and independent of clk, force state IDLE, valve=0, pump=000, busy=0, done=0, aborted=0, step=0, and clear all counters and latched durations.
REQ-032 SHALL, when reset is asserted mid-run, abandon the run without a done or aborted pulse; after release the block SHALL wait in IDLE for a new start.

Verification
REQ-033 SHALL be verified with all durations 2, reps=1 and PUMP_DIV=1: step sequence 1,1,2,2,3,3,4,4,5,5,6,6,7,0; done on the 13th cycle after start; busy high for 13 cycles.
REQ-034 SHALL be verified with dur_wash=3 and reps=2: WASH lasts 6 contiguous cycles; with reps=0, WASH lasts 3 cycles.
REQ-035 SHALL be verified with PUMP_DIV=2 and dur_load=14: pump reads 110,110,100,100,... and wraps to 110 at cycle 12 of LOAD; in BIND, pump=000.
REQ-036 SHALL be verified with all durations 0: done at T+1, IDLE at T+2, valve stays 0.
REQ-037 SHALL be verified with abort during LYSE: next cycle step=0, valve=0, pump=000, a single aborted pulse and no done pulse.
REQ-038 SHALL be verified by asserting rst_n=0 between clock edges during WASH: outputs clear without a clock edge; start after release runs a full sequence.
